// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state type and PS/2 prefix constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] KC_BRK_HI = 8'hF0;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises both PS/2 pins, glitch-filters the clock and flags its falling edges
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_evt,
  output logic data_s
);
  logic [1:0] csync, dsync;
  logic [FILTER_LEN-1:0] taps;
  logic filt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csync <= '1;
      dsync <= '1;
      taps  <= '1;
      filt  <= 1'b1;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
      taps  <= {taps[FILTER_LEN-2:0], csync[1]};
      filt  <= &taps ? 1'b1 : ~|taps ? 1'b0 : filt;
    end
  end
  assign fall_evt = filt & ~|taps;
  assign data_s = dsync[1];
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver folding E0/F0 prefixes into 16-bit keycodes
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        extended,
  output logic        key_valid,
  output logic        frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  rx_state_t state, state_n;
  logic fall_evt, data_s, good;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] sh, sh_n;
  logic par, par_n, ext_flag, ext_n, brk_flag, brk_n, ex_n, kv_n, fe_n;
  logic [15:0] kc_n;
  logic [TW-1:0] to_cnt, to_n;
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .fall_evt(fall_evt), .data_s(data_s)
  );
  assign good = data_s & ^{sh, par};
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    ext_n = ext_flag;
    brk_n = brk_flag;
    kc_n = keycode;
    ex_n = extended;
    kv_n = 1'b0;
    fe_n = 1'b0;
    to_n = (state == IDLE || fall_evt) ? '0 : to_cnt + 1'b1;
    if (fall_evt) begin
      case (state)
        IDLE: begin
          state_n = data_s ? IDLE : DATA;
          bit_n = '0;
        end
        DATA: begin
          sh_n = {data_s, sh[7:1]};
          bit_n = bit_cnt + 1'b1;
          state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n = data_s;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          if (!good) begin
            fe_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end else if (sh == PS2_EXT) begin
            ext_n = 1'b1;
          end else if (sh == PS2_BRK) begin
            brk_n = 1'b1;
          end else begin
            kc_n = {brk_flag ? KC_BRK_HI : 8'h00, sh};
            ex_n = ext_flag;
            kv_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
      endcase
    end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      ext_n = 1'b0;
      brk_n = 1'b0;
      fe_n = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      keycode <= '0;
      extended <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      to_cnt <= '0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      par <= par_n;
      ext_flag <= ext_n;
      brk_flag <= brk_n;
      keycode <= kc_n;
      extended <= ex_n;
      key_valid <= kv_n;
      frame_err <= fe_n;
      to_cnt <= to_n;
    end
  end
endmodule
